// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// inst_fetch_fifo
// Dual-issue instruction buffer between fetch and decode. Up to two
// instructions (with PCs) are written per cycle and the two oldest entries are
// presented first-word-fall-through. full_o is the fetch backpressure.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   flush_i               discard all entries (redirect / exception)
//   push1_i, push2_i      write slot 1 / slot 2 (slot 2 only with slot 1)
//   inst1_i, pc1_i        older incoming instruction and its PC
//   inst2_i, pc2_i        younger incoming instruction and its PC
//   pop_cnt_i             entries consumed by decode (0..2, 3 acts as 2)
//   valid1_o, inst1_o, pc1_o   head entry (data zero when invalid)
//   valid2_o, inst2_o, pc2_o   second entry (data zero when invalid)
//   empty_o, full_o, count_o   occupancy status
// -----------------------------------------------------------------------------
module inst_fetch_fifo #(
   parameter int DEPTH  = 16,
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              push1_i,
   input  logic              push2_i,
   input  logic [INST_W-1:0] inst1_i,
   input  logic [PC_W-1:0]   pc1_i,
   input  logic [INST_W-1:0] inst2_i,
   input  logic [PC_W-1:0]   pc2_i,
   input  logic [1:0]        pop_cnt_i,
   output logic              valid1_o,
   output logic [INST_W-1:0] inst1_o,
   output logic [PC_W-1:0]   pc1_o,
   output logic              valid2_o,
   output logic [INST_W-1:0] inst2_o,
   output logic [PC_W-1:0]   pc2_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [INST_W-1:0] instMem [DEPTH];
   logic [PC_W-1:0]   pcMem   [DEPTH];

   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtrPlus1;
   logic [PTR_W-1:0] wrPtrPlus1;
   logic [CNT_W-1:0] count;

   logic             full;
   logic [1:0]       pushN;
   logic [1:0]       popReq;
   logic [1:0]       popN;

   // Backpressure looks only at the registered count, so a same-cycle pop
   // never lets extra pushes in.
   always_comb begin
      full = (count > CNT_W'(DEPTH - 2));
   end

   always_comb begin
      pushN = 2'd0;
      if (!full && push1_i) begin
         pushN = push2_i ? 2'd2 : 2'd1;
      end
   end

   // Over-pop is clamped to what is actually stored.
   always_comb begin
      popReq = (pop_cnt_i == 2'd3) ? 2'd2 : pop_cnt_i;
      popN   = popReq;
      if (count < CNT_W'(popReq)) begin
         popN = count[1:0];
      end
   end

   always_comb begin
      rdPtrPlus1 = rdPtr + PTR_W'(1);
      wrPtrPlus1 = wrPtr + PTR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush_i) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         rdPtr <= rdPtr + PTR_W'(popN);
         wrPtr <= wrPtr + PTR_W'(pushN);
         count <= count + CNT_W'(pushN) - CNT_W'(popN);
      end
   end

   // Storage has no reset; contents are only observable through valid entries.
   always_ff @(posedge clk) begin
      if (rst && !flush_i && (pushN != 2'd0)) begin
         instMem[wrPtr] <= inst1_i;
         pcMem[wrPtr]   <= pc1_i;
         if (pushN == 2'd2) begin
            instMem[wrPtrPlus1] <= inst2_i;
            pcMem[wrPtrPlus1]   <= pc2_i;
         end
      end
   end

   always_comb begin
      valid1_o = (count != '0);
      valid2_o = (count >= CNT_W'(2));
      inst1_o  = valid1_o ? instMem[rdPtr]      : '0;
      pc1_o    = valid1_o ? pcMem[rdPtr]        : '0;
      inst2_o  = valid2_o ? instMem[rdPtrPlus1] : '0;
      pc2_o    = valid2_o ? pcMem[rdPtrPlus1]   : '0;
      empty_o  = (count == '0);
      full_o   = full;
      count_o  = count;
   end

endmodule

// File: tb/tb_inst_fetch_fifo.sv
module tb_inst_fetch_fifo;

   localparam int DEPTH  = 16;
   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush_i;
   logic              push1_i;
   logic              push2_i;
   logic [INST_W-1:0] inst1_i;
   logic [PC_W-1:0]   pc1_i;
   logic [INST_W-1:0] inst2_i;
   logic [PC_W-1:0]   pc2_i;
   logic [1:0]        pop_cnt_i;
   logic              valid1_o;
   logic [INST_W-1:0] inst1_o;
   logic [PC_W-1:0]   pc1_o;
   logic              valid2_o;
   logic [INST_W-1:0] inst2_o;
   logic [PC_W-1:0]   pc2_o;
   logic              empty_o;
   logic              full_o;
   logic [CNT_W-1:0]  count_o;

   inst_fetch_fifo #(
      .DEPTH (DEPTH),
      .INST_W(INST_W),
      .PC_W  (PC_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .push1_i  (push1_i),
      .push2_i  (push2_i),
      .inst1_i  (inst1_i),
      .pc1_i    (pc1_i),
      .inst2_i  (inst2_i),
      .pc2_i    (pc2_i),
      .pop_cnt_i(pop_cnt_i),
      .valid1_o (valid1_o),
      .inst1_o  (inst1_o),
      .pc1_o    (pc1_o),
      .valid2_o (valid2_o),
      .inst2_o  (inst2_o),
      .pc2_o    (pc2_o),
      .empty_o  (empty_o),
      .full_o   (full_o),
      .count_o  (count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rstN;
      logic        flush;
      logic        p1;
      logic        p2;
      logic [31:0] i1;
      logic [31:0] pc1;
      logic [31:0] i2;
      logic [31:0] pc2;
      logic [1:0]  pop;
      int          expCount;
      logic [31:0] expInst1;
      logic [31:0] expPc1;
      logic [31:0] expInst2;
      logic [31:0] expPc2;
      logic        expFull;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic rstN, input logic flush,
                      input logic p1, input logic p2,
                      input logic [31:0] i1, input logic [31:0] pc1,
                      input logic [31:0] i2, input logic [31:0] pc2,
                      input logic [1:0] pop, input int ec,
                      input logic [31:0] ei1, input logic [31:0] ep1,
                      input logic [31:0] ei2, input logic [31:0] ep2,
                      input logic efull);
      vec_t v;
      v.name = name; v.rstN = rstN; v.flush = flush; v.p1 = p1; v.p2 = p2;
      v.i1 = i1; v.pc1 = pc1; v.i2 = i2; v.pc2 = pc2; v.pop = pop;
      v.expCount = ec; v.expInst1 = ei1; v.expPc1 = ep1;
      v.expInst2 = ei2; v.expPc2 = ep2; v.expFull = efull;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rstN, input logic flush, input logic p1, input logic p2,
                        input logic [31:0] i1, input logic [31:0] pc1,
                        input logic [31:0] i2, input logic [31:0] pc2, input logic [1:0] pop);
      rst = rstN; flush_i = flush; push1_i = p1; push2_i = p2;
      inst1_i = i1; pc1_i = pc1; inst2_i = i2; pc2_i = pc2; pop_cnt_i = pop;
   endtask

   initial begin
      logic [31:0] q[$];
      int          pushed;
      int          popped;
      int          accepted;
      int          want;
      int          popNum;
      logic [1:0]  popCnt;

      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0);

      // name rstN flush p1 p2 i1 pc1 i2 pc2 pop | count inst1 pc1 inst2 pc2 full
      add("rst_hold0",   0, 0, 1, 0, 32'hAA, 32'hA00, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add("rst_hold1",   0, 0, 1, 0, 32'hAA, 32'hA00, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      add("rst_release", 1, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
      add("dual_push",   1, 0, 1, 1, 32'h11, 32'h100, 32'h22, 32'h104, 0,
                         2, 32'h11, 32'h100, 32'h22, 32'h104, 0);
      add("pop1",        1, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'h22, 32'h104, 0, 0, 0);
      add("pop1_empty",  1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
      for (int j = 0; j < 8; j++) begin
         add($sformatf("fill_pair%0d", j), 1, 0, 1, 1,
             32'h100 + 32'(2*j), 32'h400 + 32'(8*j), 32'h101 + 32'(2*j), 32'h404 + 32'(8*j), 0,
             2*(j+1), 32'h100, 32'h400, 32'h101, 32'h404, (j == 7) ? 1'b1 : 1'b0);
      end
      add("drop_pair",   1, 0, 1, 1, 32'h110, 32'h440, 32'h111, 32'h444, 0,
                         16, 32'h100, 32'h400, 32'h101, 32'h404, 1);
      add("pop2_unfull", 1, 0, 0, 0, 0, 0, 0, 0, 2,  14, 32'h102, 32'h408, 32'h103, 32'h40C, 0);
      add("push_to15",   1, 0, 1, 0, 32'h1F0, 32'h4F0, 0, 0, 0, 15, 32'h102, 32'h408, 32'h103, 32'h40C, 1);
      add("drop_at15",   1, 0, 1, 0, 32'h1F1, 32'h4F4, 0, 0, 0, 15, 32'h102, 32'h408, 32'h103, 32'h40C, 1);
      add("pop_no_free", 1, 0, 1, 1, 32'h1F2, 32'h4F8, 32'h1F3, 32'h4FC, 2,
                         13, 32'h104, 32'h410, 32'h105, 32'h414, 0);
      add("flush_full",  1, 1, 1, 1, 32'hEE, 32'hE00, 32'hEF, 32'hE04, 2,  0, 0, 0, 0, 0, 0);
      add("push_55",     1, 0, 1, 0, 32'h55, 32'h500, 0, 0, 0,  1, 32'h55, 32'h500, 0, 0, 0);
      add("overpop_push",1, 0, 1, 0, 32'h33, 32'h600, 0, 0, 2,  1, 32'h33, 32'h600, 0, 0, 0);
      add("pop3_clamp",  1, 0, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
      add("fill5_a",     1, 0, 1, 1, 32'h60, 32'h700, 32'h61, 32'h704, 0,  2, 32'h60, 32'h700, 32'h61, 32'h704, 0);
      add("fill5_b",     1, 0, 1, 1, 32'h62, 32'h708, 32'h63, 32'h70C, 0,  4, 32'h60, 32'h700, 32'h61, 32'h704, 0);
      add("fill5_c",     1, 0, 1, 0, 32'h64, 32'h710, 0, 0, 0,  5, 32'h60, 32'h700, 32'h61, 32'h704, 0);
      add("flush5",      1, 1, 1, 1, 32'hD0, 32'hD00, 32'hD1, 32'hD04, 2,  0, 0, 0, 0, 0, 0);
      add("push_77",     1, 0, 1, 0, 32'h77, 32'h800, 0, 0, 0,  1, 32'h77, 32'h800, 0, 0, 0);
      add("push2_only",  1, 0, 0, 1, 0, 0, 32'h99, 32'h900, 0,  1, 32'h77, 32'h800, 0, 0, 0);
      add("rst_over_fl", 0, 1, 1, 1, 32'hB0, 32'hB00, 32'hB1, 32'hB04, 2,  0, 0, 0, 0, 0, 0);

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].rstN, vecs[k].flush, vecs[k].p1, vecs[k].p2,
               vecs[k].i1, vecs[k].pc1, vecs[k].i2, vecs[k].pc2, vecs[k].pop);
         @(posedge clk);
         #1;
         chk({vecs[k].name, "_count"}, 64'(count_o), 64'(vecs[k].expCount));
         chk({vecs[k].name, "_empty"}, 64'(empty_o), 64'(vecs[k].expCount == 0));
         chk({vecs[k].name, "_full"},  64'(full_o),  64'(vecs[k].expFull));
         chk({vecs[k].name, "_v1"},    64'(valid1_o), 64'(vecs[k].expCount >= 1));
         chk({vecs[k].name, "_v2"},    64'(valid2_o), 64'(vecs[k].expCount >= 2));
         chk({vecs[k].name, "_inst1"}, 64'(inst1_o), 64'(vecs[k].expInst1));
         chk({vecs[k].name, "_pc1"},   64'(pc1_o),   64'(vecs[k].expPc1));
         chk({vecs[k].name, "_inst2"}, 64'(inst2_o), 64'(vecs[k].expInst2));
         chk({vecs[k].name, "_pc2"},   64'(pc2_o),   64'(vecs[k].expPc2));
      end

      // Wrap-around stream: 40 sequential PCs, producer re-presents dropped pushes.
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0);
      @(posedge clk);
      pushed = 0;
      popped = 0;
      for (int cyc = 0; cyc < 600 && popped < 40; cyc++) begin
         @(negedge clk);
         chk("wrap_count", 64'(count_o), 64'(q.size()));
         chk("wrap_full",  64'(full_o),  64'(q.size() > DEPTH - 2));
         chk("wrap_bound", 64'(count_o <= CNT_W'(DEPTH)), 64'(1));
         if (q.size() > 0) begin
            chk("wrap_pc1",   64'(pc1_o),   64'(q[0]));
            chk("wrap_inst1", 64'(inst1_o), 64'({16'hC0DE, q[0][15:0]}));
         end
         if (q.size() > 1) begin
            chk("wrap_pc2", 64'(pc2_o), 64'(q[1]));
         end
         want   = (40 - pushed > 2) ? 2 : 40 - pushed;
         popCnt = (cyc < 20) ? (($urandom_range(0, 2) == 0) ? 2'd2 : 2'd0)
                             : 2'($urandom_range(0, 3));
         drive(1'b1, 1'b0, want >= 1, want >= 2,
               {16'hC0DE, 16'(pushed*4)}, 32'(pushed*4),
               {16'hC0DE, 16'(pushed*4 + 4)}, 32'(pushed*4 + 4), popCnt);
         accepted = (q.size() > DEPTH - 2) ? 0 : want;
         popNum   = (popCnt == 2'd3) ? 2 : int'(popCnt);
         if (popNum > q.size()) popNum = q.size();
         for (int n = 0; n < popNum; n++) begin
            void'(q.pop_front());
            popped++;
         end
         for (int n = 0; n < accepted; n++) begin
            q.push_back(32'((pushed + n) * 4));
         end
         pushed += accepted;
         @(posedge clk);
      end
      chk("wrap_done", 64'(popped), 64'(40));

      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0);
      @(posedge clk);
      #1;
      chk("wrap_end_empty", 64'(empty_o), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
